// File: rtl/ipsxe_fft_sdf_r2_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipsxe_fft_sdf_r2_stage_pkg
// Description : Shared types and width constants for the radix-2 SDF stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ipsxe_fft_sdf_r2_stage_pkg;

    typedef enum logic {
        PH_STORE = 1'b0,
        PH_BFLY  = 1'b1
    } phase_e;

    localparam int c_GROWTH_BITS = 1;

endpackage : ipsxe_fft_sdf_r2_stage_pkg
`default_nettype wire

// File: rtl/ipsxe_fft_sdf_r2_stage_shreg.sv
`default_nettype none
// ============================================================================
// Module      : ipsxe_fft_sdf_r2_stage_shreg
// Description : Fixed-latency distributed shift register with clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module ipsxe_fft_sdf_r2_stage_shreg #(
    parameter int WIDTH       = 34,
    parameter int FIXED_DEPTH = 8,
    parameter int OUT_REG     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clken,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem_q [FIXED_DEPTH];
    logic [WIDTH-1:0] w_mem_d [FIXED_DEPTH];

    always_comb begin
        for (int i = 0; i < FIXED_DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
        end
        if (i_clken) begin
            w_mem_d[0] = i_din;
            for (int i = 1; i < FIXED_DEPTH; i++) begin
                w_mem_d[i] = r_mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIXED_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIXED_DEPTH; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_dout_q;
            logic [WIDTH-1:0] w_dout_d;

            always_comb begin
                w_dout_d = i_clken ? r_mem_q[FIXED_DEPTH-1] : r_dout_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout_q <= '0;
                end else begin
                    r_dout_q <= w_dout_d;
                end
            end

            assign o_dout = r_dout_q;
        end else begin : g_comb_out
            assign o_dout = r_mem_q[FIXED_DEPTH-1];
        end
    endgenerate

endmodule : ipsxe_fft_sdf_r2_stage_shreg
`default_nettype wire

// File: rtl/ipsxe_fft_sdf_r2_stage.sv
`default_nettype none
// ============================================================================
// Module      : ipsxe_fft_sdf_r2_stage
// Description : Radix-2 DIF single-path-delay-feedback butterfly stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ipsxe_fft_sdf_r2_stage
    import ipsxe_fft_sdf_r2_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DELAY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_re,
    input  logic [DATA_WIDTH-1:0] i_im,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic [DATA_WIDTH:0]   o_re,
    output logic [DATA_WIDTH:0]   o_im
);

    localparam int              c_OW       = DATA_WIDTH + c_GROWTH_BITS;
    localparam int              c_CW       = LOG2_DELAY + 1;
    localparam int              c_D        = 1 << LOG2_DELAY;
    localparam logic [c_CW-1:0] c_CNT_D    = c_CW'(c_D);
    localparam logic [c_CW-1:0] c_CNT_LAST = {c_CW{1'b1}};

    logic [c_CW-1:0]   r_cnt_q, w_cnt_d, w_cnt_eff;
    logic              r_primed_q, w_primed_d, w_primed_eff;
    logic              r_primed2_q, w_primed2_d, w_primed2_eff;
    logic              r_sof_pend_q, w_sof_pend_d, w_sof_pend_eff;
    logic              r_valid_q, w_valid_d;
    logic              r_sof_q, w_sof_d;
    logic [c_OW-1:0]   r_re_q, w_re_d;
    logic [c_OW-1:0]   r_im_q, w_im_d;

    logic              w_sof_in, w_realign, w_at_first_bfly, w_cand_ok;
    phase_e            w_phase;
    logic [c_OW-1:0]   w_in_re, w_in_im, w_dly_re, w_dly_im;
    logic [c_OW-1:0]   w_sum_re, w_sum_im, w_diff_re, w_diff_im;
    logic [c_OW-1:0]   w_cand_re, w_cand_im;
    logic [2*c_OW-1:0] w_fb_din, w_fb_dout;

    ipsxe_fft_sdf_r2_stage_shreg #(
        .WIDTH       (2 * c_OW),
        .FIXED_DEPTH (c_D),
        .OUT_REG     (0)
    ) u_fb_delay (
        .clk     (clk),
        .rst     (rst),
        .i_clken (i_valid),
        .i_din   (w_fb_din),
        .o_dout  (w_fb_dout)
    );

    always_comb begin
        w_sof_in        = i_valid & i_sof;
        // An i_sof landing mid-block restarts the block and drops stored differences.
        w_realign       = w_sof_in & (r_cnt_q != '0);
        w_cnt_eff       = w_sof_in ? '0 : r_cnt_q;
        w_phase         = phase_e'(w_cnt_eff[c_CW-1]);
        w_at_first_bfly = (w_cnt_eff == c_CNT_D);
        w_primed_eff    = r_primed_q & ~w_realign;
        w_primed2_eff   = r_primed2_q & ~w_realign;
        w_sof_pend_eff  = r_sof_pend_q | w_sof_in;

        w_in_re   = {i_re[DATA_WIDTH-1], i_re};
        w_in_im   = {i_im[DATA_WIDTH-1], i_im};
        w_dly_re  = w_fb_dout[2*c_OW-1:c_OW];
        w_dly_im  = w_fb_dout[c_OW-1:0];
        w_sum_re  = w_dly_re + w_in_re;
        w_sum_im  = w_dly_im + w_in_im;
        w_diff_re = w_dly_re - w_in_re;
        w_diff_im = w_dly_im - w_in_im;

        w_cnt_d      = r_cnt_q;
        w_primed_d   = w_primed_eff;
        w_primed2_d  = w_primed2_eff;
        w_sof_pend_d = w_sof_pend_eff;
        if (i_valid) begin
            w_cnt_d = w_cnt_eff + 1'b1;
            if (w_at_first_bfly) begin
                w_primed_d   = 1'b1;
                w_sof_pend_d = 1'b0;
            end
            if (w_cnt_eff == c_CNT_LAST) begin
                w_primed2_d = 1'b1;
            end
        end

        if (w_phase == PH_BFLY) begin
            w_fb_din  = {w_diff_re, w_diff_im};
            w_cand_re = w_sum_re;
            w_cand_im = w_sum_im;
            w_cand_ok = w_primed_eff | w_at_first_bfly;
        end else begin
            w_fb_din  = {w_in_re, w_in_im};
            w_cand_re = w_dly_re;
            w_cand_im = w_dly_im;
            w_cand_ok = w_primed2_eff;
        end

        w_valid_d = i_valid & w_cand_ok;
        w_sof_d   = i_valid & w_at_first_bfly & w_sof_pend_eff;
        w_re_d    = i_valid ? w_cand_re : r_re_q;
        w_im_d    = i_valid ? w_cand_im : r_im_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q      <= '0;
            r_primed_q   <= 1'b0;
            r_primed2_q  <= 1'b0;
            r_sof_pend_q <= 1'b0;
            r_valid_q    <= 1'b0;
            r_sof_q      <= 1'b0;
            r_re_q       <= '0;
            r_im_q       <= '0;
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_primed_q   <= w_primed_d;
            r_primed2_q  <= w_primed2_d;
            r_sof_pend_q <= w_sof_pend_d;
            r_valid_q    <= w_valid_d;
            r_sof_q      <= w_sof_d;
            r_re_q       <= w_re_d;
            r_im_q       <= w_im_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_sof   = r_sof_q;
    assign o_re    = r_re_q;
    assign o_im    = r_im_q;

endmodule : ipsxe_fft_sdf_r2_stage
`default_nettype wire

// File: tb/tb_ipsxe_fft_sdf_r2_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipsxe_fft_sdf_r2_stage
// Description : Self-checking bench for the SDF stage (D=4 and D=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipsxe_fft_sdf_r2_stage;

    typedef struct {
        logic              sof;
        logic signed [7:0] re;
        logic signed [7:0] im;
        logic              ev;
        logic              esof;
        logic signed [8:0] ere;
        logic signed [8:0] eim;
    } vec_t;

    typedef struct packed {
        logic              sof;
        logic signed [8:0] re;
        logic signed [8:0] im;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_a = 1'b0, sof_a = 1'b0;
    logic signed [7:0] re_a = '0, im_a = '0;
    logic              ovalid_a, osof_a;
    logic signed [8:0] ore_a, oim_a;
    logic              valid_b = 1'b0, sof_b = 1'b0;
    logic signed [7:0] re_b = '0, im_b = '0;
    logic              ovalid_b, osof_b;
    logic signed [8:0] ore_b, oim_b;

    vec_t  vecs[$];
    exp_t  q_a[$];
    exp_t  q_b[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    string cur = "init";

    always #5 clk = ~clk;

    ipsxe_fft_sdf_r2_stage #(.DATA_WIDTH(8), .LOG2_DELAY(2)) u_dut_a (
        .clk(clk), .rst(rst), .i_valid(valid_a), .i_sof(sof_a), .i_re(re_a), .i_im(im_a),
        .o_valid(ovalid_a), .o_sof(osof_a), .o_re(ore_a), .o_im(oim_a)
    );

    ipsxe_fft_sdf_r2_stage #(.DATA_WIDTH(8), .LOG2_DELAY(0)) u_dut_b (
        .clk(clk), .rst(rst), .i_valid(valid_b), .i_sof(sof_b), .i_re(re_b), .i_im(im_b),
        .o_valid(ovalid_b), .o_sof(osof_b), .o_re(ore_b), .o_im(oim_b)
    );

    task automatic add(input logic s, input int re, input int im,
                       input logic ev, input logic es, input int ere, input int eim);
        vec_t v;
        v.sof = s;   v.re = 8'(re);   v.im = 8'(im);
        v.ev  = ev;  v.esof = es;     v.ere = 9'(ere); v.eim = 9'(eim);
        vecs.push_back(v);
    endtask

    task automatic mon(input string dut, input logic ov, input logic os,
                       input logic signed [8:0] r, input logic signed [8:0] i, inout exp_t q[$]);
        exp_t e;
        if (ov) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL %s/%s: unexpected o_valid, got sof=%0b re=%0d im=%0d, required no output",
                         cur, dut, os, r, i);
            end else begin
                e = q.pop_front();
                if (os !== e.sof || r !== e.re || i !== e.im) begin
                    n_fail++;
                    $display("FAIL %s/%s: got sof=%0b re=%0d im=%0d, required sof=%0b re=%0d im=%0d",
                             cur, dut, os, r, i, e.sof, e.re, e.im);
                end
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        mon("a", ovalid_a, osof_a, ore_a, oim_a, q_a);
        mon("b", ovalid_b, osof_b, ore_b, oim_b, q_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_a = 1'b0; sof_a = 1'b0;
        valid_b = 1'b0; sof_b = 1'b0;
        tick();
    endtask

    task automatic drive(input vec_t v, input bit use_b);
        exp_t e;
        e.sof = v.esof; e.re = v.ere; e.im = v.eim;
        if (use_b) begin
            valid_a = 1'b0; sof_a = 1'b0;
            valid_b = 1'b1; sof_b = v.sof; re_b = v.re; im_b = v.im;
            if (v.ev) q_b.push_back(e);
        end else begin
            valid_b = 1'b0; sof_b = 1'b0;
            valid_a = 1'b1; sof_a = v.sof; re_a = v.re; im_a = v.im;
            if (v.ev) q_a.push_back(e);
        end
        tick();
    endtask

    task automatic run(input int first, input int last, input bit use_b, input bit gaps);
        for (int k = first; k <= last; k++) begin
            drive(vecs[k], use_b);
            if (gaps) idle();
        end
    endtask

    task automatic drain();
        repeat (3) idle();
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL %s/drain: outputs still owed a=%0d b=%0d, required 0 0",
                     cur, q_a.size(), q_b.size());
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, required %0d", cur, name, act, req);
        end
    endtask

    task automatic chk_reset_a();
        chk("rst_o_valid", int'(ovalid_a), 0);
        chk("rst_o_sof",   int'(osof_a),   0);
        chk("rst_o_re",    int'(ore_a),    0);
        chk("rst_o_im",    int'(oim_a),    0);
    endtask

    initial begin
        int c1, c2, c5, cb;

        c1 = vecs.size();
        add(1, 1, 0, 0, 0, 0, 0);    add(0, 2, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0);    add(0, 4, 0, 0, 0, 0, 0);
        add(0, 5, 0, 1, 1, 6, 0);    add(0, 6, 0, 1, 0, 8, 0);
        add(0, 7, 0, 1, 0, 10, 0);   add(0, 8, 0, 1, 0, 12, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 0, -4, 0);

        c2 = vecs.size();
        add(1, -128, 127, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, -128, 127, 0, 0, 0, 0);
        add(0, -128, 127, 1, 1, -256, 254);
        for (int k = 0; k < 3; k++) add(0, -128, 127, 1, 0, -256, 254);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 0, 0, 0);

        c5 = vecs.size();
        add(1, 10, 0, 1, 0, -4, 0);  add(0, 20, 0, 1, 0, -4, 0);
        add(1, 30, 5, 0, 0, 0, 0);   add(0, 31, 5, 0, 0, 0, 0);
        add(0, 32, 5, 0, 0, 0, 0);   add(0, 33, 5, 0, 0, 0, 0);
        add(0, 40, -5, 1, 1, 70, 0); add(0, 41, -5, 1, 0, 72, 0);
        add(0, 42, -5, 1, 0, 74, 0); add(0, 43, -5, 1, 0, 76, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 0, -10, 10);

        cb = vecs.size();
        add(1, 3, 0, 0, 0, 0, 0);    add(0, 1, 0, 1, 1, 4, 0);
        add(0, 5, 0, 1, 0, 2, 0);    add(0, 2, 0, 1, 0, 7, 0);
        add(0, 0, 0, 1, 0, 3, 0);

        cur = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_a();
        chk("rst_b_valid", int'(ovalid_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cur = "continuous";
        run(c1, c1 + 11, 1'b0, 1'b0);
        drain();

        cur = "extremes";
        run(c2, c2 + 11, 1'b0, 1'b0);
        drain();

        cur = "gaps";
        run(c1, c1 + 11, 1'b0, 1'b1);
        drain();

        cur = "midreset";
        run(c1, c1 + 4, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk_reset_a();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(c1, c1 + 11, 1'b0, 1'b0);
        drain();

        cur = "early_sof";
        run(c1, c1 + 7, 1'b0, 1'b0);
        run(c5, c5 + 13, 1'b0, 1'b0);
        drain();

        cur = "d1";
        run(cb, cb + 4, 1'b1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ipsxe_fft_sdf_r2_stage
`default_nettype wire
